// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 engine: MSB-first, no reflection, no final XOR.
// IDLE -> SHIFT (FRAME_BITS accepted bits) -> DONE (one cycle) -> IDLE or SHIFT.
module crc8_serial #(
  parameter int         FRAME_BITS = 16,
  parameter logic [7:0] POLY       = 8'h07,
  parameter logic [7:0] INIT       = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inStart,
  input  logic       inValid,
  input  logic       inBit,
  output logic       outReady,
  output logic       outBusy,
  output logic       outDone,
  output logic [7:0] outCrc
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      out_crc_q, out_crc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fb;
  logic [7:0]      crc_step;

  assign fb       = crc_q[7] ^ inBit;
  assign crc_step = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      count_q   <= '0;
      out_crc_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      count_q   <= count_d;
      out_crc_q <= out_crc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    count_d   = count_q;
    out_crc_d = out_crc_q;
    unique case (state_q)
      IDLE: begin
        if (inStart) begin
          crc_d   = INIT;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A restart wins over the bit presented in the same cycle.
        if (inStart) begin
          crc_d   = INIT;
          count_d = '0;
        end else if (inValid) begin
          crc_d   = crc_step;
          count_d = count_q + CW'(1);
          if (count_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        out_crc_d = crc_q;
        if (inStart) begin
          crc_d   = INIT;
          count_d = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outReady = (state_q == SHIFT);
    outBusy  = (state_q != IDLE);
    outDone  = (state_q == DONE);
    outCrc   = out_crc_q;
  end

endmodule

// File: tb/tb_crc8_serial.sv
// Directed bench for crc8_serial: one instance with 8-bit frames, one with 16-bit frames.
module tb_crc8_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_start, a_valid, a_bit, a_ready, a_busy, a_done;
  logic [7:0] a_crc;
  logic       b_start, b_valid, b_bit, b_ready, b_busy, b_done;
  logic [7:0] b_crc;

  int errors = 0;
  int checks = 0;

  crc8_serial #(.FRAME_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .inStart(a_start), .inValid(a_valid), .inBit(a_bit),
    .outReady(a_ready), .outBusy(a_busy), .outDone(a_done), .outCrc(a_crc)
  );

  crc8_serial #(.FRAME_BITS(16)) dut16 (
    .clk(clk), .rst(rst), .inStart(b_start), .inValid(b_valid), .inBit(b_bit),
    .outReady(b_ready), .outBusy(b_busy), .outDone(b_done), .outCrc(b_crc)
  );

  function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
    logic f;
    f = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
  endfunction

  task automatic a_send(input logic v);
    a_valid = 1'b1; a_bit = v;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic b_send(input logic v);
    b_valid = 1'b1; b_bit = v;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic b_go();
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_start = 0; a_valid = 0; a_bit = 0;
    b_start = 0; b_valid = 0; b_bit = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b_ready, b_busy, b_done, b_crc} !== 11'h000) begin
      errors++;
      $display("FAIL reset16: got ready=%b busy=%b done=%b crc=%h, want 0 0 0 00", b_ready, b_busy, b_done, b_crc);
    end
    checks++;
    if ({a_ready, a_busy, a_done, a_crc} !== 11'h000) begin
      errors++;
      $display("FAIL reset8: got ready=%b busy=%b done=%b crc=%h, want 0 0 0 00", a_ready, a_busy, a_done, a_crc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_ff8();
    logic [7:0] d;
    d = 8'hFF;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL ff8_shift: ready=%b busy=%b, want 1 1", a_ready, a_busy);
    end
    for (int i = 7; i >= 0; i--) a_send(d[i]);
    checks++;
    if (a_done !== 1'b1 || a_ready !== 1'b0 || a_crc !== 8'h00) begin
      errors++;
      $display("FAIL ff8_done: done=%b ready=%b crc=%h, want 1 0 00", a_done, a_ready, a_crc);
    end
    @(posedge clk); #1;
    checks++;
    if (a_crc !== 8'hF3 || a_done !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL ff8_crc: crc=%h done=%b busy=%b, want F3 0 0", a_crc, a_done, a_busy);
    end
    $display("frame8 data=FF crc=%h", a_crc);
  endtask

  task automatic test_gaps();
    logic [15:0] d;
    logic [7:0]  m;
    int          cnt;
    int          g;
    d = 16'h0100; m = 8'h00; cnt = 0;
    b_go();
    for (int i = 15; i >= 0; i--) begin
      b_send(d[i]);
      m = crc_bit(m, d[i]);
      cnt++;
      if (i > 0) begin
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          @(posedge clk); #1;
          checks++;
          if (dut16.crc_q !== m || int'(dut16.count_q) != cnt || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL gap_hold: crc=%h count=%0d ready=%b, want %h %0d 1", dut16.crc_q, dut16.count_q, b_ready, m, cnt);
          end
        end
      end
    end
    checks++;
    if (b_done !== 1'b1) begin
      errors++;
      $display("FAIL gap_done: done=%b, want 1", b_done);
    end
    @(posedge clk); #1;
    checks++;
    if (b_crc !== 8'h15 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL gap_crc: crc=%h done=%b, want 15 0", b_crc, b_done);
    end
    $display("frame16 gaps data=0100 crc=%h", b_crc);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    d = 16'h0000;
    b_go();
    for (int i = 15; i >= 0; i--) b_send(d[i]);
    b_start = 1'b1;
    checks++;
    if (b_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b, want 1", b_done);
    end
    @(posedge clk); #1;
    b_start = 1'b0;
    checks++;
    if (b_crc !== 8'h00 || b_ready !== 1'b1 || b_busy !== 1'b1 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: crc=%h ready=%b busy=%b done=%b, want 00 1 1 0", b_crc, b_ready, b_busy, b_done);
    end
    $display("frame16 data=0000 crc=%h", b_crc);
    d = 16'h0100;
    for (int i = 15; i >= 0; i--) b_send(d[i]);
    @(posedge clk); #1;
    checks++;
    if (b_crc !== 8'h15 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: crc=%h busy=%b, want 15 0", b_crc, b_busy);
    end
    $display("frame16 b2b data=0100 crc=%h", b_crc);
  endtask

  task automatic test_restart();
    logic [15:0] d;
    d = 16'h0100;
    b_go();
    for (int i = 0; i < 5; i++) b_send(1'b1);
    b_start = 1'b1; b_valid = 1'b1; b_bit = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_valid = 1'b0;
    checks++;
    if (dut16.crc_q !== 8'h00 || int'(dut16.count_q) != 0 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: crc=%h count=%0d ready=%b, want 00 0 1", dut16.crc_q, dut16.count_q, b_ready);
    end
    for (int i = 15; i >= 0; i--) b_send(d[i]);
    @(posedge clk); #1;
    checks++;
    if (b_crc !== 8'h15) begin
      errors++;
      $display("FAIL restart_crc: crc=%h, want 15", b_crc);
    end
    $display("frame16 restart data=0100 crc=%h", b_crc);
  endtask

  task automatic test_idle_ignore();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      a_valid = 1'b1; a_bit = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (a_crc !== 8'hF3 || a_done !== 1'b0 || a_ready !== 1'b0) bad++;
    end
    a_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_ignore: %0d bad cycles (crc=%h done=%b ready=%b), want 0 (F3 0 0)", bad, a_crc, a_done, a_ready);
    end
    $display("idle 20 cycles crc=%h", a_crc);
  endtask

  task automatic test_async_reset();
    int bad;
    bad = 0;
    b_go();
    for (int i = 0; i < 10; i++) b_send(1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (b_ready !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_crc !== 8'h00) begin
      errors++;
      $display("FAIL async_rst: ready=%b busy=%b done=%b crc=%h, want 0 0 0 00", b_ready, b_busy, b_done, b_crc);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b_valid = 1'b1; b_bit = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (b_done !== 1'b0 || b_ready !== 1'b0 || b_busy !== 1'b0 || b_crc !== 8'h00) bad++;
    end
    b_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_rst_idle: %0d bad cycles (done=%b ready=%b busy=%b crc=%h), want 0", bad, b_done, b_ready, b_busy, b_crc);
    end
    $display("async reset after 10 bits crc=%h", b_crc);
  endtask

  initial begin
    test_reset();
    test_ff8();
    test_gaps();
    test_back_to_back();
    test_restart();
    test_idle_ignore();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
